// File: rtl/register_file_nport.sv
// Multi-port register file: DEPTH x n storage, two combinational read ports, one
// synchronous write port, optional hard-wired x0 and same-cycle write forwarding.
module register_file_nport #(
  parameter int n        = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [n-1:0]  wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [n-1:0]  rdata1,
  output logic [n-1:0]  rdata2
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [n-1:0]  regs [DEPTH];
  logic          wr_acc;
  logic [AW-1:0] raddr [2];
  logic [n-1:0]  rdata [2];

  // Out-of-range and x0 writes are dropped here so neither storage nor bypass sees them.
  assign wr_acc = we && !rst && ({1'b0, waddr} < DEPTH_L) &&
                  !((ZERO_REG != 0) && (waddr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (waddr == AW'(i)) regs[i] <= wdata;
      end
    end
  end

  assign raddr[0] = raddr1;
  assign raddr[1] = raddr2;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      rdata[p] = '0;
      if ({1'b0, raddr[p]} >= DEPTH_L) begin
        rdata[p] = '0;
      end else if ((ZERO_REG != 0) && (raddr[p] == '0)) begin
        rdata[p] = '0;
      end else if ((BYPASS != 0) && wr_acc && (waddr == raddr[p])) begin
        rdata[p] = wdata;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (raddr[p] == AW'(i)) rdata[p] = regs[i];
        end
      end
    end
  end

  assign rdata1 = rdata[0];
  assign rdata2 = rdata[1];

endmodule

// File: doc/register_file_nport.md
# register_file_nport

Parametrised general-purpose register file for the RISCV_Processor datapath: `DEPTH` registers of `n` bits each, two asynchronous read ports and one synchronous write port. It replaces per-register instantiation in the decode stage. It also adds three behaviours: an optional hard-wired zero register (x0), optional same-cycle write-to-read bypass, and ignoring of out-of-range addresses for non-power-of-two depths. Operand reads feed the ALU-source muxes; the write port is driven by the writeback stage.

## Interface
- `n`, 32, data width of every register.
- `DEPTH`, 32, number of registers; must be ≥ 2; `AW = $clog2(DEPTH)`.
- `ZERO_REG`, 1, when 1 register 0 always reads 0 and ignores writes.
- `BYPASS`, 1, when 1 a write in progress is forwarded to matching read ports in the same cycle.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset; clears all registers.
- `we`  in  1  write enable.
- `waddr`  in  AW  write address.
- `wdata`  in  n  write data.
- `raddr1`  in  AW  read address, port 1.
- `raddr2`  in  AW  read address, port 2.
- `rdata1`  out  n  read data, port 1 (combinational).
- `rdata2`  out  n  read data, port 2 (combinational).

## Operation
- **Storage:** `DEPTH` × `n` flops, each register loaded only when selected by the write decode. Non-selected registers hold their value.
- **Write accept:** a write is accepted when `we`=1, `rst`=0, `waddr` < `DEPTH`, and not (`ZERO_REG`=1 and `waddr`=0).
- **Write commit:** an accepted write stores `wdata` into `regs[waddr]` at the rising edge of `clk`.
- **Read value:** `rdataK = regs[raddrK]`, with the following overrides in priority order:
  1. `raddrK` ≥ `DEPTH` → 0.
  2. `ZERO_REG`=1 and `raddrK`=0 → 0.
  3. `BYPASS`=1 and the write is accepted this cycle and `waddr`=`raddrK` → `wdata`.
  4. Otherwise → stored value.
- **Independent ports:** both read ports are independent; identical addresses on both ports return identical data.
- **Width rules:** no arithmetic; data passes unmodified; `n` bits in, `n` bits out.

## Timing
- **Reset:**
  - Asserting `rst` clears every register to 0 immediately, with no clock required.
  - While `rst`=1, writes are blocked and the bypass is disabled, so `rdata1`/`rdata2` = 0 for every address.
- **Reset mid-operation:** a write whose edge coincides with `rst` high is lost. The register reads 0 after reset.
- **Read latency:** 0 cycles (combinational from address and storage).
- **Write-to-read latency:**
  - `BYPASS`=0: new data is visible on the read ports from the cycle after the edge.
  - `BYPASS`=1: new data is also visible combinationally in the write cycle itself.
- **Simultaneous read and write:** both read ports and the write port may target the same register in one cycle.
  - `BYPASS`=1: both ports return `wdata`.
  - `BYPASS`=0: both ports return the old value.
- **Back-to-back writes:** writes to the same address on consecutive cycles commit in order; the last write wins.
- **Address boundaries:**
  - Address wrap does not occur.
  - Out-of-range addresses (non-power-of-two `DEPTH`) are inert for writes and read 0.
- **Combinational paths:** no combinational path from `wdata` to `rdataK` exists when `BYPASS`=0.

## Test plan
- **Reset clear:** write 0xDEADBEEF to x5, assert `rst` mid-cycle without a clock edge → `rdata1`(x5) reads 0x00000000 immediately; after deassert, x5 still reads 0.
- **Write/read, x0, all registers (defaults):**
  - write 0x12345678 to x0 → reads 0.
  - write 0xA5A5A5A5 to x31 → `rdata2`(x31) = 0xA5A5A5A5 next cycle.
  - sweep all 32 addresses with value = address × 0x01010101 → each read back exactly.
- **Bypass on (`BYPASS`=1):**
  - setup: x7 = 0x11111111; next cycle `we`=1, `waddr`=7, `wdata`=0x22222222, `raddr1`=`raddr2`=7.
  - response: both read 0x22222222 in the same cycle.
  - with `waddr`=0 under the same conditions → both ports read 0.
- **Bypass off (`BYPASS`=0):** same stimulus as the bypass-on case → both ports read 0x11111111 in the write cycle, then 0x22222222 after the edge.
- **`DEPTH`=24, `n`=16, `ZERO_REG`=0:**
  - write 0xBEEF to x0 → reads 0xBEEF.
  - write 0xCAFE to address 27 → no register changes, `rdata1`(27) = 0.
  - write to x23 → reads back.
- **Write blocked during reset:** hold `rst`=1 with `we`=1, `waddr`=3, `wdata`=0xFFFFFFFF across 3 clock edges; deassert → x3 reads 0.
